// File: rtl/wb_pkg.sv
// Shared definitions for the write-back arbiter: widths, the buffered
// entry layout and the wrap-aware tag age comparison.
package wb_pkg;

  localparam int DATAW = 32;
  localparam int TAGW  = 4;
  localparam int REGW  = 5;

  typedef struct packed {
    logic [REGW-1:0]  rd;
    logic [DATAW-1:0] data;
    logic [TAGW-1:0]  tag;
  } wb_entry_t;

  // True when tag a was issued before tag b: (a - b) mod 2^w has its MSB set.
  // Tags are passed zero-extended; the low w bits of the difference do not
  // depend on the upper bits, so one body serves any tag width up to 32.
  function automatic logic tag_older(input logic [31:0] a,
                                     input logic [31:0] b,
                                     input int unsigned w = TAGW);
    logic [31:0] diff;
    diff = (a - b) >> (w - 1);
    return diff[0];
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small per-channel result buffer. The head entry is visible combinationally
// so the arbiter can pick and pop it in the same cycle it becomes valid.
// Ready is a flop driven from next-cycle occupancy, so it never depends on
// this cycle's inputs and is held low during reset.
module wb_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wb_pkg::wb_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  output logic   in_ready,
  input  entry_t in_data,
  input  logic   pop,
  output logic   head_valid,
  output entry_t head
);
  import wb_pkg::*;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          ready_reg;
  logic          push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign push       = in_valid & ready_reg;
  assign in_ready   = ready_reg;
  assign head_valid = (count_reg != '0);
  assign do_pop     = pop & head_valid;
  assign head       = mem[rd_ptr_reg];

  // Occupancy after this cycle's push/pop; a simultaneous push and pop cancel.
  always_comb begin
    count_next = count_reg;
    if (push && !do_pop)
      count_next = count_reg + 1'b1;
    else if (!push && do_pop)
      count_next = count_reg - 1'b1;
  end

  // Entry storage; contents need no reset because occupancy gates their use.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= in_data;
  end

  // Pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ready_reg  <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (do_pop)
        rd_ptr_reg <= next_ptr(rd_ptr_reg);
      count_reg <= count_next;
      ready_reg <= (count_next != CW'(DEPTH));
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: two result channels (ALU on A, MEM/MUL on B) are each
// buffered, and every cycle the older head by issue tag is popped and written
// to the register file through a registered write port. Writes to x0 are
// consumed without touching the port.
module wb_arbiter #(
  parameter int DATAW = wb_pkg::DATAW,
  parameter int TAGW  = wb_pkg::TAGW,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [4:0]       a_rd,
  input  logic [DATAW-1:0] a_data,
  input  logic [TAGW-1:0]  a_tag,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [4:0]       b_rd,
  input  logic [DATAW-1:0] b_data,
  input  logic [TAGW-1:0]  b_tag,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [DATAW-1:0] rf_wdata,
  output logic [DATAW-1:0] writedata
);
  import wb_pkg::*;

  typedef struct packed {
    logic [REGW-1:0]  rd;
    logic [DATAW-1:0] data;
    logic [TAGW-1:0]  tag;
  } entry_t;

  // Channel 0 is A, channel 1 is B.
  entry_t     in_ent   [2];
  entry_t     head_ent [2];
  logic [1:0] in_valid, in_ready, head_valid, pop;
  logic       b_older;
  entry_t     sel;

  assign in_valid  = {b_valid, a_valid};
  assign in_ent[0] = '{rd: a_rd, data: a_data, tag: a_tag};
  assign in_ent[1] = '{rd: b_rd, data: b_data, tag: b_tag};
  assign a_ready   = in_ready[0];
  assign b_ready   = in_ready[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      wb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
      ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid[gi]),
        .in_ready   (in_ready[gi]),
        .in_data    (in_ent[gi]),
        .pop        (pop[gi]),
        .head_valid (head_valid[gi]),
        .head       (head_ent[gi])
      );
    end
  endgenerate

  // Grant B only when it is strictly older (or alone); ties go to A.
  always_comb begin
    b_older = tag_older(32'(head_ent[1].tag), 32'(head_ent[0].tag), TAGW);
    pop     = 2'b00;
    pop[1]  = head_valid[1] & (~head_valid[0] | b_older);
    pop[0]  = head_valid[0] & ~pop[1];
    sel     = pop[1] ? head_ent[1] : head_ent[0];
  end

  // Registered write port; address/data hold unless a nonzero rd is granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      writedata <= '0;
    end else begin
      rf_we <= 1'b0;
      if ((|pop) && (sel.rd != '0)) begin
        rf_we     <= 1'b1;
        rf_waddr  <= sel.rd;
        rf_wdata  <= sel.data;
        writedata <= sel.data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a per-cycle vector table for the steady-state
// behaviour, then hand-written sequences for reset, backpressure and a
// mid-operation reset.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_rd, b_rd;
  logic [31:0] a_data, b_data;
  logic [3:0]  a_tag, b_tag;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, writedata;

  wb_arbiter #(.DATAW(32), .TAGW(4), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_rd      (a_rd),
    .a_data    (a_data),
    .a_tag     (a_tag),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_rd      (b_rd),
    .b_data    (b_data),
    .b_tag     (b_tag),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .writedata (writedata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic [3:0] t);
    a_valid = v; a_rd = rd; a_data = d; a_tag = t;
  endtask

  task automatic set_b(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic [3:0] t);
    b_valid = v; b_rd = rd; b_data = d; b_tag = t;
  endtask

  // Write monitor: records every register-file write while enabled.
  logic        mon_en = 1'b0;
  logic [36:0] wlog [$];
  always @(posedge clk) begin
    #1;
    if (mon_en && rf_we) wlog.push_back({rf_waddr, rf_wdata});
  end

  // Vector table: inputs driven before edge i, outputs expected after it.
  typedef struct {
    logic        av; logic [4:0] ard; logic [31:0] ad; logic [3:0] at;
    logic        bv; logic [4:0] brd; logic [31:0] bd; logic [3:0] bt;
    logic        we; logic [4:0] wa;  logic [31:0] wd;
  } vec_t;

  function automatic vec_t mkv(
    input logic av, input logic [4:0] ard, input logic [31:0] ad, input logic [3:0] at,
    input logic bv, input logic [4:0] brd, input logic [31:0] bd, input logic [3:0] bt,
    input logic we, input logic [4:0] wa, input logic [31:0] wd);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.at = at;
    v.bv = bv; v.brd = brd; v.bd = bd; v.bt = bt;
    v.we = we; v.wa = wa; v.wd = wd;
    return v;
  endfunction

  localparam int NV = 17;
  vec_t vecs [NV];

  typedef struct packed { logic [4:0] rd; logic [31:0] d; logic [3:0] t; } item_t;
  item_t       pa [3];
  item_t       pb [2];
  logic [36:0] bp_exp [5];

  int   ai, bi;
  logic at_x, bt_x, saw_full;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //                a  rd  data          tag  b  rd  data          tag  we wa  wd
    vecs[0]  = mkv(1, 5, 32'h0000_00AA, 3, 0, 0, 32'h0,      0, 0, 0, 32'h0);
    vecs[1]  = mkv(0, 0, 32'h0,         0, 0, 0, 32'h0,      0, 1, 5, 32'hAA);
    vecs[2]  = mkv(0, 0, 32'h0,         0, 0, 0, 32'h0,      0, 0, 5, 32'hAA);
    vecs[3]  = mkv(1, 7, 32'h11,        1, 1, 9, 32'h22,     15, 0, 5, 32'hAA);
    vecs[4]  = mkv(0, 0, 32'h0,         0, 0, 0, 32'h0,      0, 1, 9, 32'h22);
    vecs[5]  = mkv(0, 0, 32'h0,         0, 0, 0, 32'h0,      0, 1, 7, 32'h11);
    vecs[6]  = mkv(1, 3, 32'h33,        2, 1, 4, 32'h44,     2, 0, 7, 32'h11);
    vecs[7]  = mkv(0, 0, 32'h0,         0, 0, 0, 32'h0,      0, 1, 3, 32'h33);
    vecs[8]  = mkv(0, 0, 32'h0,         0, 0, 0, 32'h0,      0, 1, 4, 32'h44);
    vecs[9]  = mkv(0, 0, 32'h0,         0, 1, 0, 32'h1234,   5, 0, 4, 32'h44);
    vecs[10] = mkv(0, 0, 32'h0,         0, 0, 0, 32'h0,      0, 0, 4, 32'h44);
    vecs[11] = mkv(0, 0, 32'h0,         0, 0, 0, 32'h0,      0, 0, 4, 32'h44);
    vecs[12] = mkv(1, 1, 32'hA1,        6, 0, 0, 32'h0,      0, 0, 4, 32'h44);
    vecs[13] = mkv(1, 2, 32'hA2,        7, 0, 0, 32'h0,      0, 1, 1, 32'hA1);
    vecs[14] = mkv(1, 3, 32'hA3,        8, 0, 0, 32'h0,      0, 1, 2, 32'hA2);
    vecs[15] = mkv(0, 0, 32'h0,         0, 0, 0, 32'h0,      0, 1, 3, 32'hA3);
    vecs[16] = mkv(0, 0, 32'h0,         0, 0, 0, 32'h0,      0, 0, 3, 32'hA3);

    pb[0] = '{rd: 5'd10, d: 32'hB9, t: 4'd9};
    pb[1] = '{rd: 5'd11, d: 32'hBA, t: 4'd10};
    pa[0] = '{rd: 5'd12, d: 32'hAB, t: 4'd11};
    pa[1] = '{rd: 5'd13, d: 32'hAC, t: 4'd12};
    pa[2] = '{rd: 5'd14, d: 32'hAD, t: 4'd13};
    bp_exp[0] = {5'd10, 32'hB9};
    bp_exp[1] = {5'd11, 32'hBA};
    bp_exp[2] = {5'd12, 32'hAB};
    bp_exp[3] = {5'd13, 32'hAC};
    bp_exp[4] = {5'd14, 32'hAD};

    // Reset held for 3 cycles with A trying to push.
    set_a(1, 5'd3, 32'hFFFF, 4'd0);
    set_b(0, 5'd0, 32'h0, 4'd0);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("reset%0d rf_we", i), {31'b0, rf_we}, 32'd0);
      chk($sformatf("reset%0d writedata", i), writedata, 32'd0);
      chk($sformatf("reset%0d a_ready", i), {31'b0, a_ready}, 32'd0);
      chk($sformatf("reset%0d b_ready", i), {31'b0, b_ready}, 32'd0);
    end
    rst = 1'b1;
    set_a(0, 5'd0, 32'h0, 4'd0);
    tick;
    chk("post-reset a_ready", {31'b0, a_ready}, 32'd1);
    chk("post-reset b_ready", {31'b0, b_ready}, 32'd1);
    chk("post-reset rf_we", {31'b0, rf_we}, 32'd0);
    chk("post-reset rf_waddr", {27'b0, rf_waddr}, 32'd0);

    // Table-driven steady-state vectors.
    for (int i = 0; i < NV; i++) begin
      set_a(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].at);
      set_b(vecs[i].bv, vecs[i].brd, vecs[i].bd, vecs[i].bt);
      tick;
      chk($sformatf("row%0d rf_we", i), {31'b0, rf_we}, {31'b0, vecs[i].we});
      chk($sformatf("row%0d rf_waddr", i), {27'b0, rf_waddr}, {27'b0, vecs[i].wa});
      chk($sformatf("row%0d rf_wdata", i), rf_wdata, vecs[i].wd);
      chk($sformatf("row%0d writedata", i), writedata, vecs[i].wd);
      chk($sformatf("row%0d a_ready", i), {31'b0, a_ready}, 32'd1);
      chk($sformatf("row%0d b_ready", i), {31'b0, b_ready}, 32'd1);
    end
    set_a(0, 5'd0, 32'h0, 4'd0);
    set_b(0, 5'd0, 32'h0, 4'd0);
    tick;

    // Backpressure: B carries older tags, A pushes three times and must stall.
    wlog.delete();
    mon_en   = 1'b1;
    ai       = 0;
    bi       = 0;
    saw_full = 1'b0;
    for (int cyc = 0; cyc < 20 && !(ai == 3 && bi == 2); cyc++) begin
      if (ai < 3) set_a(1, pa[ai].rd, pa[ai].d, pa[ai].t);
      else        set_a(0, 5'd0, 32'h0, 4'd0);
      if (bi < 2) set_b(1, pb[bi].rd, pb[bi].d, pb[bi].t);
      else        set_b(0, 5'd0, 32'h0, 4'd0);
      at_x = a_valid && a_ready;
      bt_x = b_valid && b_ready;
      tick;
      if (at_x) ai++;
      if (bt_x) bi++;
      if (!a_ready) saw_full = 1'b1;
    end
    set_a(0, 5'd0, 32'h0, 4'd0);
    set_b(0, 5'd0, 32'h0, 4'd0);
    chk("bp all pushes accepted", {31'b0, (ai == 3 && bi == 2)}, 32'd1);
    chk("bp a_ready dropped", {31'b0, saw_full}, 32'd1);
    repeat (4) tick;
    mon_en = 1'b0;
    chk("bp write count", wlog.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < wlog.size()) begin
        chk($sformatf("bp write%0d addr", i), {27'b0, wlog[i][36:32]}, {27'b0, bp_exp[i][36:32]});
        chk($sformatf("bp write%0d data", i), wlog[i][31:0], bp_exp[i][31:0]);
      end
    end

    // Mid-operation reset with two entries buffered.
    set_a(1, 5'd20, 32'hDEAD, 4'd0);
    set_b(1, 5'd21, 32'hBEEF, 4'd1);
    tick;
    set_a(0, 5'd0, 32'h0, 4'd0);
    set_b(0, 5'd0, 32'h0, 4'd0);
    rst = 1'b0;
    #1;
    chk("midrst rf_we", {31'b0, rf_we}, 32'd0);
    chk("midrst writedata", writedata, 32'd0);
    chk("midrst a_ready", {31'b0, a_ready}, 32'd0);
    tick;
    rst = 1'b1;
    wlog.delete();
    mon_en = 1'b1;
    repeat (5) tick;
    mon_en = 1'b0;
    chk("midrst no stale writes", wlog.size(), 32'd0);
    chk("midrst writedata held", writedata, 32'd0);

    // Normal operation resumes with two-cycle latency.
    set_a(1, 5'd6, 32'h66, 4'd1);
    tick;
    set_a(0, 5'd0, 32'h0, 4'd0);
    chk("resume edge N rf_we", {31'b0, rf_we}, 32'd0);
    tick;
    chk("resume edge N+1 rf_we", {31'b0, rf_we}, 32'd1);
    chk("resume rf_waddr", {27'b0, rf_waddr}, 32'd6);
    chk("resume rf_wdata", rf_wdata, 32'h66);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter DATAW, default 32: result and register-file data width.
REQ-002 Parameter TAGW, default 4: issue sequence tag width.
REQ-003 Parameter DEPTH, default 2: per-channel buffer entries.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low (0 = in reset).
REQ-006 a_valid / a_ready  in / out  1 / 1  ALU result handshake; transfer when both are 1 at a rising edge.
REQ-007 a_rd, a_data, a_tag  in  5, DATAW, TAGW  ALU destination register, result value, issue tag.
REQ-008 b_valid / b_ready, b_rd, b_data, b_tag  same widths  MEM/MUL result channel.
REQ-009 rf_we  out  1  register-file write enable, registered.
REQ-010 rf_waddr, rf_wdata  out  5, DATAW  register-file write address and data, registered.
REQ-011 writedata  out  DATAW  last value actually written to the register file.

Function
REQ-012 Each channel has one FIFO of DEPTH entries {rd, data, tag}; x_ready = not full, from registered occupancy only, with no combinational path from any input.
REQ-013 A push while full cannot occur because ready is 0, even when a pop happens in the same cycle.
REQ-014 Each cycle with at least one non-empty FIFO, exactly one head is granted and popped.
REQ-015 With both heads valid, grant the older tag: A is older iff (a_tag - b_tag) mod 2^TAGW has its MSB set (wrap-aware).
REQ-016 Equal tags grant A.
REQ-017 With one head valid, that head is granted regardless of tag.
REQ-018 On grant with rd != 0, next edge: rf_we = 1, rf_waddr = rd, rf_wdata = data, writedata = data.
REQ-019 On grant with rd == 0, the entry is popped; next cycle rf_we = 0; rf_waddr, rf_wdata and writedata hold their values.
REQ-020 With no grant, next cycle rf_we = 0 and the other outputs hold.
REQ-021 Latency: an entry accepted at edge N into an empty FIFO, with no competing older head, produces rf_we = 1 in the cycle after edge N+1 (2 cycles).
REQ-022 Push and pop on the same FIFO in the same cycle are both performed; occupancy is unchanged.
REQ-023 Throughput: at most one register-file write per cycle.
REQ-024 Sustained single-channel streaming with DEPTH = 2 runs at 1 entry/cycle with no bubble.

Reset
REQ-025 While rst = 0, asynchronously: both FIFOs empty; rf_we = 0; rf_waddr = 0; rf_wdata = 0; writedata = 0.
REQ-026 While rst = 0, a_ready = b_ready = 0; both become 1 in the first cycle after rst rises.
REQ-027 Assertion of rst mid-operation discards all buffered entries; no write of a discarded entry ever appears after release.

Structure
REQ-028 A shared package wb_pkg holds DATAW, TAGW, REGW = 5, the entry struct {rd, data, tag}, and the function tag_older(a, b).
REQ-029 One sub-module, wb_fifo (parameterised on DEPTH and the entry type), is instantiated twice; arbitration and the output register live in wb_arbiter.

Verification
REQ-030 Reset: hold rst = 0 for 3 cycles with a_valid = 1 -> rf_we = 0, writedata = 0, a_ready = 0; a_ready = 1 in the first cycle after rst rises.
REQ-031 Single write: push A {rd=5, data=0x0000_00AA, tag=3} at edge N -> rf_we = 1, rf_waddr = 5, rf_wdata = 0xAA after edge N+1; writedata = 0xAA thereafter.
REQ-032 Conflict with wrap: push A tag=1 and B tag=15 at the same edge -> B written first, A the next cycle; repeat with A tag=2, B tag=2 -> A written first.
REQ-033 $zero drop: push B {rd=0, data=0x1234} -> entry popped, rf_we stays 0, writedata unchanged.
REQ-034 Backpressure: push A three times back-to-back while B holds two older heads -> a_ready = 0 when A's FIFO holds 2 entries; all 5 writes appear in tag order, with none lost or duplicated.
REQ-035 Mid-operation reset: pulse rst low for 1 cycle with 2 entries buffered -> no rf_we = 1 for those entries after release.
